// File: rtl/write_back_sequencer.sv
// Write-back sequencer: steps one instruction's register write-back through
// an optional memory wait, one or two register-file writes, and a done pulse.
module write_back_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] wb_class,
  input  logic       mem_ready,
  output logic [1:0] WriteRegCtrl,
  output logic [1:0] WbSrcSel,
  output logic       RegWrite,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CLS_W = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [CLS_W-1:0] CLS_NONE  = CLS_W'(0);
  localparam logic [CLS_W-1:0] CLS_RTYPE = CLS_W'(1);
  localparam logic [CLS_W-1:0] CLS_ITYPE = CLS_W'(2);
  localparam logic [CLS_W-1:0] CLS_LINK  = CLS_W'(3);
  localparam logic [CLS_W-1:0] CLS_LOAD  = CLS_W'(4);
  localparam logic [CLS_W-1:0] CLS_POP   = CLS_W'(5);
  localparam logic [CLS_W-1:0] CLS_PUSH  = CLS_W'(6);
  localparam logic [CLS_W-1:0] CLS_RSVD  = CLS_W'(7);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WRITE1,
    S_WRITE2,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic [1:0] wr_ctrl_d, wb_src_d;
  logic       reg_write_d, busy_d, done_d, error_d;

  // Next-state logic; outputs are decoded from the next state so they register as Moore outputs
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          cls_d = wb_class;
          cnt_d = '0;
          case (wb_class)
            CLS_NONE, CLS_RSVD: state_d = S_DONE;
            CLS_LOAD, CLS_POP:  state_d = S_WAIT_MEM;
            default:            state_d = S_WRITE1;
          endcase
        end
      end
      S_WAIT_MEM: begin
        if (mem_ready) begin
          state_d = S_WRITE1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE1: state_d = (cls_q == CLS_POP) ? S_WRITE2 : S_DONE;
      S_WRITE2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    wr_ctrl_d   = 2'd0;
    wb_src_d    = 2'd0;
    reg_write_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_d)
      S_WAIT_MEM: busy_d = 1'b1;
      S_WRITE1: begin
        busy_d      = 1'b1;
        reg_write_d = 1'b1;
        case (cls_d)
          CLS_RTYPE: begin wr_ctrl_d = 2'd0; wb_src_d = 2'd0; end
          CLS_ITYPE: begin wr_ctrl_d = 2'd3; wb_src_d = 2'd0; end
          CLS_LINK:  begin wr_ctrl_d = 2'd2; wb_src_d = 2'd2; end
          CLS_LOAD,
          CLS_POP:   begin wr_ctrl_d = 2'd3; wb_src_d = 2'd1; end
          CLS_PUSH:  begin wr_ctrl_d = 2'd1; wb_src_d = 2'd3; end
          default:   begin wr_ctrl_d = 2'd0; wb_src_d = 2'd0; end
        endcase
      end
      S_WRITE2: begin
        busy_d      = 1'b1;
        reg_write_d = 1'b1;
        wr_ctrl_d   = 2'd1;
        wb_src_d    = 2'd3;
      end
      S_DONE: begin
        done_d  = 1'b1;
        error_d = (cls_d == CLS_RSVD) || abort_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cls_q        <= '0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      WriteRegCtrl <= 2'd0;
      WbSrcSel     <= 2'd0;
      RegWrite     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      WriteRegCtrl <= wr_ctrl_d;
      WbSrcSel     <= wb_src_d;
      RegWrite     <= reg_write_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
    end
  end

endmodule

// File: tb/tb_write_back_sequencer.sv
// Self-checking bench for write_back_sequencer: directed scenarios plus random
// transactions compared cycle by cycle against a per-transaction trace model.
module tb_write_back_sequencer;

  localparam int unsigned T = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] wb_class;
  logic       mem_ready;
  logic [1:0] WriteRegCtrl;
  logic [1:0] WbSrcSel;
  logic       RegWrite;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  write_back_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start(start), .wb_class(wb_class),
    .mem_ready(mem_ready), .WriteRegCtrl(WriteRegCtrl), .WbSrcSel(WbSrcSel),
    .RegWrite(RegWrite), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic rw, input logic [1:0] ctrl,
                                    input logic [1:0] src, input logic bz,
                                    input logic dn, input logic er);
    return {rw, ctrl, src, bz, dn, er};
  endfunction

  function automatic logic [7:0] obs();
    return {RegWrite, WriteRegCtrl, WbSrcSel, busy, done, error};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got={rw,ctrl,src,busy,done,err}=%b exp=%b", tag, got, exp);
    end
  endtask

  // Expected output per cycle after start; d = WAIT_MEM cycle on which mem_ready rises (0 = never)
  task automatic build(input int cls, input int d);
    logic [7:0] w1;
    exp_q.delete();
    case (cls)
      1: w1 = pk(1, 2'd0, 2'd0, 1, 0, 0);
      2: w1 = pk(1, 2'd3, 2'd0, 1, 0, 0);
      3: w1 = pk(1, 2'd2, 2'd2, 1, 0, 0);
      6: w1 = pk(1, 2'd1, 2'd3, 1, 0, 0);
      default: w1 = pk(1, 2'd3, 2'd1, 1, 0, 0);
    endcase
    if (cls == 0 || cls == 7) begin
      exp_q.push_back(pk(0, 2'd0, 2'd0, 0, 1, cls == 7));
    end else if (cls == 4 || cls == 5) begin
      if (d >= 1 && d <= int'(T)) begin
        repeat (d) exp_q.push_back(pk(0, 2'd0, 2'd0, 1, 0, 0));
        exp_q.push_back(w1);
        if (cls == 5) exp_q.push_back(pk(1, 2'd1, 2'd3, 1, 0, 0));
        exp_q.push_back(pk(0, 2'd0, 2'd0, 0, 1, 0));
      end else begin
        repeat (T) exp_q.push_back(pk(0, 2'd0, 2'd0, 1, 0, 0));
        exp_q.push_back(pk(0, 2'd0, 2'd0, 0, 1, 1));
      end
    end else begin
      exp_q.push_back(w1);
      exp_q.push_back(pk(0, 2'd0, 2'd0, 0, 1, 0));
    end
  endtask

  // Called in an IDLE cycle (#1 after an edge); returns in the IDLE cycle after done
  task automatic run_txn(input int cls, input int d, input bit noise, input string tag);
    int n;
    start     = 1'b1;
    wb_class  = 3'(cls);
    mem_ready = 1'b0;
    check_eq({tag, ":idle"}, obs(), 8'd0);
    build(cls, d);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      start     = noise ? 1'($urandom) : 1'b0;
      wb_class  = 3'($urandom);
      mem_ready = (i == d);
      check_eq($sformatf("%s:cyc%0d", tag, i), obs(), exp_q[i-1]);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    wb_class  = 3'd0;
    mem_ready = 1'b0;
    #1;
    check_eq("reset_hold", obs(), 8'd0);
    #11 reset = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_first", obs(), 8'd0);

    run_txn(1, 0, 1'b0, "rtype");
    run_txn(1, 0, 1'b0, "rtype_b2b");
    run_txn(5, 3, 1'b0, "pop_ready3");
    run_txn(4, 0, 1'b0, "load_timeout");
    run_txn(4, 15, 1'b0, "load_ready15");
    run_txn(5, 1, 1'b0, "pop_ready1");
    run_txn(7, 0, 1'b0, "reserved");
    run_txn(0, 0, 1'b0, "none");
    run_txn(3, 0, 1'b1, "link_noise");
    run_txn(6, 0, 1'b1, "push_noise");

    // Asynchronous reset in the middle of WAIT_MEM
    start    = 1'b1;
    wb_class = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_pre_busy", obs(), pk(0, 2'd0, 2'd0, 1, 0, 0));
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async", obs(), 8'd0);
    @(posedge clk); #1;
    check_eq("rst_held", obs(), 8'd0);
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check_eq("rst_release", obs(), 8'd0);
    @(posedge clk); #1;
    check_eq("rst_no_done", obs(), 8'd0);
    run_txn(2, 0, 1'b0, "itype_after_rst");

    for (int k = 0; k < 200; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check_eq("rand_gap", obs(), 8'd0);
      end
      run_txn($urandom_range(0, 7), $urandom_range(0, 20), 1'($urandom),
              $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
